// File: rtl/softex_lane_sched.sv
// softex_lane_sched: round-robin row-to-lane scheduler steering the input beat stream onto SoftEx datapath lanes
//
// Optional build macro: SOFTEX_LANE_SCHED_PERF_EN enables the saturating stall counter on perf_stall_o;
// without it perf_stall_o is tied to zero.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, row_len_i,
//   num_rows_i                   job start pulse and job shape, latched in IDLE
//   busy_o, done_o               job in progress, one-cycle job-end pulse
//   in_valid_i/in_ready_o/
//   in_data_i                    input beat stream
//   lane_valid_o, lane_ready_i,
//   lane_data_o, lane_last_o     per-lane beat handshake, broadcast data, end-of-row marker
//   lane_done_i                  per-lane row-finished pulse, frees the lane
//   perf_stall_o                 stall-cycle counter
module softex_lane_sched #(
    parameter int NUM_LANES = 4,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic [LEN_W-1:0]            row_len_i,
    input  logic [LEN_W-1:0]            num_rows_i,
    output logic                        busy_o,
    output logic                        done_o,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [DATA_W-1:0]           in_data_i,
    output logic [NUM_LANES-1:0]        lane_valid_o,
    input  logic [NUM_LANES-1:0]        lane_ready_i,
    output logic [NUM_LANES*DATA_W-1:0] lane_data_o,
    output logic [NUM_LANES-1:0]        lane_last_o,
    input  logic [NUM_LANES-1:0]        lane_done_i,
    output logic [31:0]                 perf_stall_o
);
    localparam int IDX_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {IDLE, SELECT, STREAM, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [LEN_W-1:0]     row_len, num_rows, dispatched, beat_cnt;
    logic [IDX_W-1:0]     sel, rr_ptr, cand, free_idx;
    logic [NUM_LANES-1:0] lane_busy, lane_set, sel_oh;
    logic                 free_found, accept, last_beat, rows_left, done_q;

    // Lowest-offset free lane from rr_ptr: scanning offsets downwards lets the smallest offset win.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        cand       = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr) + i) % NUM_LANES);
            if (!lane_busy[cand]) begin
                free_found = 1'b1;
                free_idx   = cand;
            end
        end
    end

    assign sel_oh       = NUM_LANES'(1) << sel;
    assign in_ready_o   = (state == STREAM) & lane_ready_i[sel];
    assign accept       = in_valid_i & in_ready_o;
    assign last_beat    = beat_cnt == row_len - LEN_W'(1);
    assign rows_left    = dispatched != num_rows;
    assign lane_valid_o = (state == STREAM && in_valid_i) ? sel_oh : '0;
    assign lane_last_o  = (state == STREAM && last_beat) ? sel_oh : '0;
    assign lane_data_o  = {NUM_LANES{in_data_i}};
    assign busy_o       = state != IDLE;
    assign done_o       = done_q;

    always_comb begin
        state_nxt = state;
        lane_set  = '0;
        case (state)
            IDLE:
                if (start_i)
                    state_nxt = (row_len_i == '0 || num_rows_i == '0) ? DRAIN : SELECT;
            SELECT:
                if (!rows_left)
                    state_nxt = DRAIN;
                else if (free_found) begin
                    state_nxt          = STREAM;
                    lane_set[free_idx] = 1'b1;
                end
            STREAM:
                if (accept && last_beat)
                    state_nxt = SELECT;
            default:
                if (lane_busy == '0)
                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            lane_busy  <= '0;
            rr_ptr     <= '0;
            sel        <= '0;
            done_q     <= 1'b0;
            row_len    <= '0;
            num_rows   <= '0;
            dispatched <= '0;
            beat_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            // A reservation made this cycle overrides a same-cycle release of that lane.
            lane_busy <= (lane_busy & ~lane_done_i) | lane_set;
            done_q    <= state == DRAIN && lane_busy == '0;
            if (state == IDLE && start_i) begin
                row_len    <= row_len_i;
                num_rows   <= num_rows_i;
                dispatched <= '0;
            end
            if (lane_set != '0) begin
                sel      <= free_idx;
                beat_cnt <= '0;
            end
            if (accept) begin
                beat_cnt <= beat_cnt + LEN_W'(1);
                if (last_beat) begin
                    dispatched <= dispatched + LEN_W'(1);
                    rr_ptr     <= (sel == IDX_W'(NUM_LANES - 1)) ? '0 : sel + IDX_W'(1);
                end
            end
        end
    end

`ifdef SOFTEX_LANE_SCHED_PERF_EN
    logic [31:0] perf_cnt;
    logic        stall;

    assign stall = (state == SELECT && rows_left && !free_found) ||
                   (state == STREAM && in_valid_i && !in_ready_o);

    always_ff @(posedge clk_i) begin
        if (rst_i)
            perf_cnt <= '0;
        else if (state == IDLE && start_i)
            perf_cnt <= '0;
        else if (stall && perf_cnt != '1)
            perf_cnt <= perf_cnt + 32'd1;
    end

    assign perf_stall_o = perf_cnt;
`else
    assign perf_stall_o = '0;
`endif

endmodule
